inst_display_scheduler: RTL and testbench

- Controls the shared 40-bit, 8-character scrolling display bus.
- Several 5-bit-character message generators (select currency, enter amount, error, ...) each drive a 40-bit shift window. Only one generator may own the display at a time.
- This block arbitrates requests from the ATM control FSM, restarts the granted generator, counts scroll passes and routes that generator's window to the display.
- It sits between the ATM control FSM, the generators and the display driver, and runs on the one-second scroll clock.

---
 rtl/inst_display_scheduler.sv | 168 ++++++++++++++++
 tb/tb_inst_display_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_display_scheduler.sv
// Purpose : fixed-priority owner of the shared 8-character scrolling display bus.
// Latency : grant -> START after 1 edge; generator window -> instruction after 1 edge.
// Backpr. : none; requests are levels, a grant runs whole passes unless preempted.
//
// Ports:
//   sec_clock   scroll tick clock, rising edge
//   rst         asynchronous active-low reset
//   req         level requests, one per message, bit 0 highest priority
//   msg_in      generator windows, slice i = [40*i+39 : 40*i]
//   gen_rst     active-high synchronous resets to the generators
//   instruction registered 40-bit window to the display driver
//   active_id   index of the granted message
//   busy        high in START or SCROLL
//   done        one-cycle pulse when a grant completes or is dropped
module inst_display_scheduler #(
   parameter int N_MSG      = 4,
   parameter int SCROLL_LEN = 29,
   parameter int REPEATS    = 2,
   parameter int PREEMPT    = 1,
   localparam int AW        = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
   input  logic                 sec_clock,
   input  logic                 rst,
   input  logic [N_MSG-1:0]     req,
   input  logic [40*N_MSG-1:0]  msg_in,
   output logic [N_MSG-1:0]     gen_rst,
   output logic [39:0]          instruction,
   output logic [AW-1:0]        active_id,
   output logic                 busy,
   output logic                 done
);

   localparam int TW = (SCROLL_LEN > 1) ? $clog2(SCROLL_LEN) : 1;
   localparam int RW = (REPEATS > 0) ? $clog2(REPEATS + 1) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_LEN - 1);
   // With REPEATS==0 the pass counter is never compared against a limit.
   localparam logic [RW-1:0] REP_LAST  = (REPEATS > 0) ? RW'(REPEATS - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_START  = 2'd1,
      S_SCROLL = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   id_nxt;
   logic [TW-1:0]   tick_cnt, tick_nxt;
   logic [RW-1:0]   rep_cnt, rep_nxt;
   logic [39:0]     instr_nxt;

   logic [AW-1:0]   win_id;
   logic            win_vld;
   logic [39:0]     cur_win;
   logic            cur_req;
   logic            preempt_hit;
   logic            pass_end;
   logic            last_rep;

   // Fixed-priority winner (lowest index) and the granted generator's window/request.
   always_comb begin
      win_id  = '0;
      win_vld = 1'b0;
      for (int i = N_MSG - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_id  = AW'(i);
            win_vld = 1'b1;
         end
      end
      cur_win = '0;
      cur_req = 1'b0;
      for (int i = 0; i < N_MSG; i++) begin
         if (active_id == AW'(i)) begin
            cur_win = msg_in[40*i +: 40];
            cur_req = req[i];
         end
      end
   end

   assign preempt_hit = (PREEMPT != 0) && win_vld && (win_id < active_id);
   assign pass_end    = (tick_cnt == TICK_LAST);
   assign last_rep    = (REPEATS != 0) && (rep_cnt == REP_LAST);

   // Next-state and datapath decisions.
   always_comb begin
      state_nxt = state;
      id_nxt    = active_id;
      tick_nxt  = tick_cnt;
      rep_nxt   = rep_cnt;
      instr_nxt = instruction;
      case (state)
         S_IDLE: begin
            instr_nxt = '0;
            if (win_vld) begin
               state_nxt = S_START;
               id_nxt    = win_id;
               tick_nxt  = '0;
               rep_nxt   = '0;
            end
         end
         S_START: begin
            // Display keeps its previous window until the new owner scrolls.
            state_nxt = S_SCROLL;
            tick_nxt  = '0;
            rep_nxt   = '0;
         end
         S_SCROLL: begin
            if (preempt_hit) begin
               // Preemption beats a coincident pass boundary; no done pulse.
               state_nxt = S_START;
               id_nxt    = win_id;
               tick_nxt  = '0;
               rep_nxt   = '0;
            end else begin
               instr_nxt = cur_win;
               if (pass_end) begin
                  tick_nxt = '0;
                  // A dropped request is only honoured at a pass boundary.
                  if (!cur_req || last_rep) begin
                     state_nxt = S_DONE;
                     instr_nxt = '0;
                  end else begin
                     rep_nxt = rep_cnt + 1'b1;
                  end
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            instr_nxt = '0;
         end
         default: begin
            state_nxt = S_IDLE;
            instr_nxt = '0;
            tick_nxt  = '0;
            rep_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge sec_clock or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         active_id   <= '0;
         tick_cnt    <= '0;
         rep_cnt     <= '0;
         instruction <= '0;
      end else begin
         state       <= state_nxt;
         active_id   <= id_nxt;
         tick_cnt    <= tick_nxt;
         rep_cnt     <= rep_nxt;
         instruction <= instr_nxt;
      end
   end

   // Moore outputs decoded from registered state; reset values follow IDLE.
   always_comb begin
      busy = (state == S_START) || (state == S_SCROLL);
      done = (state == S_DONE);
      for (int i = 0; i < N_MSG; i++) begin
         gen_rst[i] = !((state == S_SCROLL) && (active_id == AW'(i)));
      end
   end

endmodule

// File: tb/tb_inst_display_scheduler.sv
module tb_inst_display_scheduler;

   localparam int SL = 29;

   logic          sec_clock = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [159:0]  msg_in;

   // dut0: defaults; dut1: PREEMPT=0; dut2: REPEATS=0
   logic [3:0]  g0, g1, g2;
   logic [39:0] i0, i1, i2;
   logic [1:0]  a0, a1, a2;
   logic        b0, b1, b2, d0, d1, d2;

   always #5 sec_clock = ~sec_clock;

   inst_display_scheduler #(.N_MSG(4), .SCROLL_LEN(SL), .REPEATS(2), .PREEMPT(1)) dut0 (
      .sec_clock(sec_clock), .rst(rst), .req(req), .msg_in(msg_in),
      .gen_rst(g0), .instruction(i0), .active_id(a0), .busy(b0), .done(d0));
   inst_display_scheduler #(.N_MSG(4), .SCROLL_LEN(SL), .REPEATS(2), .PREEMPT(0)) dut1 (
      .sec_clock(sec_clock), .rst(rst), .req(req), .msg_in(msg_in),
      .gen_rst(g1), .instruction(i1), .active_id(a1), .busy(b1), .done(d1));
   inst_display_scheduler #(.N_MSG(4), .SCROLL_LEN(SL), .REPEATS(0), .PREEMPT(1)) dut2 (
      .sec_clock(sec_clock), .rst(rst), .req(req), .msg_in(msg_in),
      .gen_rst(g2), .instruction(i2), .active_id(a2), .busy(b2), .done(d2));

   // Reference model: phase 0 idle, 1 start, 2 scrolling, 3 done.
   typedef struct {
      int          phase;
      int          id;
      int          tk;
      int          pass;
      logic [39:0] instr;
   } mdl_t;

   mdl_t m0, m1, m2;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.phase = 0; m.id = 0; m.tk = 0; m.pass = 0; m.instr = '0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, logic [3:0] r, logic [159:0] msg, int reps, int pre);
      mdl_t n;
      int   low;
      n   = m;
      low = -1;
      for (int i = 3; i >= 0; i--) if (r[i]) low = i;
      case (m.phase)
         0: begin
            n.instr = '0;
            if (low >= 0) begin n.phase = 1; n.id = low; n.tk = 0; n.pass = 0; end
         end
         1: begin n.phase = 2; n.tk = 0; n.pass = 0; end
         2: begin
            if (pre != 0 && low >= 0 && low < m.id) begin
               n.phase = 1; n.id = low; n.tk = 0; n.pass = 0;
            end else begin
               n.instr = msg[40*m.id +: 40];
               if (m.tk == SL - 1) begin
                  n.tk = 0;
                  if (!r[m.id] || (reps != 0 && m.pass + 1 == reps)) begin
                     n.phase = 3; n.instr = '0;
                  end else begin
                     n.pass = m.pass + 1;
                  end
               end else begin
                  n.tk = m.tk + 1;
               end
            end
         end
         default: begin n.phase = 0; n.instr = '0; end
      endcase
      return n;
   endfunction

   function automatic logic [47:0] mdl_out(mdl_t m);
      logic [3:0] g;
      g = 4'hf;
      if (m.phase == 2) g[m.id] = 1'b0;
      return {g, m.instr, 2'(m.id), (m.phase == 1 || m.phase == 2), (m.phase == 3)};
   endfunction

   function automatic logic [159:0] rnd_msg();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      m0 = mdl_step(m0, req, msg_in, 2, 1);
      m1 = mdl_step(m1, req, msg_in, 2, 0);
      m2 = mdl_step(m2, req, msg_in, 0, 1);
      @(posedge sec_clock);
      #1;
      cyc++;
      msg_in = rnd_msg();
   endtask

   task automatic do_reset();
      @(negedge sec_clock);
      rst = 1'b0;
      req = '0;
      m0 = mdl_reset(); m1 = mdl_reset(); m2 = mdl_reset();
      @(posedge sec_clock);
      #1;
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; msg_in = rnd_msg();
      #12;
      checks++;
      if (g0 !== 4'hf) begin errors++; $display("FAIL reset_gen_rst got=%b want=1111", g0); end
      checks++;
      if (i0 !== 40'h0) begin errors++; $display("FAIL reset_instruction got=%h want=0", i0); end
      checks++;
      if ({a0, b0, d0} !== 4'b0) begin errors++; $display("FAIL reset_id_busy_done got=%b want=0000", {a0, b0, d0}); end
   endtask

   task automatic test_hold_repeat();
      int first_done;
      first_done = -1;
      do_reset();
      req = 4'b0100;
      for (int k = 0; k < 64; k++) begin
         tick();
         checks++;
         if ({g0, i0, a0, b0, d0} !== mdl_out(m0)) begin
            errors++; $display("FAIL hold cyc=%0d got=%h want=%h", cyc, {g0, i0, a0, b0, d0}, mdl_out(m0));
         end
         if (d0 && first_done < 0) first_done = cyc;
         if (cyc == 1) begin
            checks++;
            if ({a0, b0, g0} !== {2'd2, 1'b1, 4'hf}) begin errors++; $display("FAIL hold_start got=%b want=1011111", {a0, b0, g0}); end
         end
         if (cyc == 2) begin
            checks++;
            if (g0 !== 4'b1011) begin errors++; $display("FAIL hold_gen_rst got=%b want=1011", g0); end
         end
         if (cyc == 61) begin
            checks++;
            if ({b0, i0} !== 41'h0) begin errors++; $display("FAIL hold_blank got=%h want=0", {b0, i0}); end
         end
         if (cyc == 62) begin
            checks++;
            if ({b0, a0} !== 3'b110) begin errors++; $display("FAIL hold_regrant got=%b want=110", {b0, a0}); end
         end
      end
      checks++;
      if (first_done != 60) begin errors++; $display("FAIL hold_done_cycle got=%0d want=60", first_done); end
   endtask

   task automatic test_priority();
      do_reset();
      req = 4'b1010;
      for (int k = 0; k < 35; k++) begin
         tick();
         if (cyc == 2) req = 4'b1000;
         checks++;
         if ({g0, i0, a0, b0, d0} !== mdl_out(m0)) begin
            errors++; $display("FAIL prio cyc=%0d got=%h want=%h", cyc, {g0, i0, a0, b0, d0}, mdl_out(m0));
         end
         if (cyc == 1) begin
            checks++;
            if (a0 !== 2'd1) begin errors++; $display("FAIL prio_id got=%0d want=1", a0); end
         end
         if (cyc == 2) begin
            checks++;
            if (g0 !== 4'b1101) begin errors++; $display("FAIL prio_gen_rst got=%b want=1101", g0); end
         end
      end
      checks++;
      if ({a0, b0} !== 3'b111) begin errors++; $display("FAIL prio_next_id got=%b want=111", {a0, b0}); end
   endtask

   task automatic test_drop_mid_pass();
      int first_done;
      first_done = -1;
      do_reset();
      req = 4'b0100;
      for (int k = 0; k < 34; k++) begin
         tick();
         if (cyc == 12) req = 4'b0000;
         checks++;
         if ({g0, i0, a0, b0, d0} !== mdl_out(m0)) begin
            errors++; $display("FAIL drop cyc=%0d got=%h want=%h", cyc, {g0, i0, a0, b0, d0}, mdl_out(m0));
         end
         if (d0 && first_done < 0) first_done = cyc;
         if (cyc == 30) begin
            checks++;
            if ({b0, g0} !== 5'b11011) begin errors++; $display("FAIL drop_still_scrolling got=%b want=11011", {b0, g0}); end
         end
         if (cyc == 31) begin
            checks++;
            if ({d0, i0} !== {1'b1, 40'h0}) begin errors++; $display("FAIL drop_done got=%h want=%h", {d0, i0}, {1'b1, 40'h0}); end
         end
      end
      checks++;
      if (first_done != 31) begin errors++; $display("FAIL drop_done_cycle got=%0d want=31", first_done); end
   endtask

   task automatic test_preempt();
      int np_bad;
      int np_done;
      np_bad = 0; np_done = -1;
      do_reset();
      req = 4'b1000;
      for (int k = 0; k < 62; k++) begin
         tick();
         if (cyc == 7) req = 4'b1001;
         checks++;
         if ({g0, i0, a0, b0, d0} !== mdl_out(m0)) begin
            errors++; $display("FAIL preempt cyc=%0d got=%h want=%h", cyc, {g0, i0, a0, b0, d0}, mdl_out(m0));
         end
         checks++;
         if ({g1, i1, a1, b1, d1} !== mdl_out(m1)) begin
            errors++; $display("FAIL nopreempt cyc=%0d got=%h want=%h", cyc, {g1, i1, a1, b1, d1}, mdl_out(m1));
         end
         if (cyc == 8) begin
            checks++;
            if ({a0, b0, d0, g0} !== 8'b00101111) begin errors++; $display("FAIL preempt_start got=%b want=00101111", {a0, b0, d0, g0}); end
         end
         if (cyc >= 2 && cyc <= 60 && a1 !== 2'd3) np_bad++;
         if (d1 && np_done < 0) np_done = cyc;
      end
      checks++;
      if (np_bad != 0) begin errors++; $display("FAIL nopreempt_id_held got=%0d cycles_changed want=0", np_bad); end
      checks++;
      if (np_done != 60) begin errors++; $display("FAIL nopreempt_done_cycle got=%0d want=60", np_done); end
   endtask

   task automatic test_repeat_forever();
      int dones;
      int idle_cycles;
      int first_done;
      dones = 0; idle_cycles = 0; first_done = -1;
      do_reset();
      req = 4'b0010;
      for (int k = 0; k < 125; k++) begin
         tick();
         if (cyc == 100) req = 4'b0000;
         checks++;
         if ({g2, i2, a2, b2, d2} !== mdl_out(m2)) begin
            errors++; $display("FAIL forever cyc=%0d got=%h want=%h", cyc, {g2, i2, a2, b2, d2}, mdl_out(m2));
         end
         if (cyc <= 100 && d2) dones++;
         if (cyc <= 100 && !b2) idle_cycles++;
         if (cyc > 100 && d2 && first_done < 0) first_done = cyc;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL forever_no_done got=%0d want=0", dones); end
      checks++;
      if (idle_cycles != 0) begin errors++; $display("FAIL forever_busy got=%0d idle cycles want=0", idle_cycles); end
      checks++;
      if (first_done != 118) begin errors++; $display("FAIL forever_done_cycle got=%0d want=118", first_done); end
   endtask

   task automatic test_async_reset();
      int bad;
      bad = 0;
      do_reset();
      req = 4'b0100;
      repeat (20) tick();
      #3;
      rst = 1'b0;
      #1;
      m0 = mdl_reset(); m1 = mdl_reset(); m2 = mdl_reset();
      checks++;
      if ({g0, i0, a0, b0, d0} !== {4'hf, 40'h0, 2'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL async_reset got=%h want=%h", {g0, i0, a0, b0, d0}, {4'hf, 44'h0});
      end
      req = 4'b0000;
      @(posedge sec_clock);
      #1;
      rst = 1'b1;
      cyc = 0;
      repeat (5) begin
         tick();
         if (b0 !== 1'b0 || g0 !== 4'hf) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL async_idle_wait got=%0d busy cycles want=0", bad); end
      req = 4'b0001;
      tick();
      checks++;
      if ({a0, b0} !== 3'b001) begin errors++; $display("FAIL async_regrant got=%b want=001", {a0, b0}); end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
         tick();
         checks++;
         if ({g0, i0, a0, b0, d0} !== mdl_out(m0)) begin
            errors++; $display("FAIL rand0 cyc=%0d got=%h want=%h", cyc, {g0, i0, a0, b0, d0}, mdl_out(m0));
         end
         checks++;
         if ({g1, i1, a1, b1, d1} !== mdl_out(m1)) begin
            errors++; $display("FAIL rand1 cyc=%0d got=%h want=%h", cyc, {g1, i1, a1, b1, d1}, mdl_out(m1));
         end
         checks++;
         if ({g2, i2, a2, b2, d2} !== mdl_out(m2)) begin
            errors++; $display("FAIL rand2 cyc=%0d got=%h want=%h", cyc, {g2, i2, a2, b2, d2}, mdl_out(m2));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hold_repeat();
      test_priority();
      test_drop_mid_pass();
      test_preempt();
      test_repeat_forever();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
